// File: rtl/neosd_pkg.sv
// neosd_pkg: register map, flag bits, command-word fields and FSM
// encodings shared by the neosd multi-block read sequencer.
package neosd_pkg;

    localparam logic [7:0] REG_FLAGS = 8'h08;
    localparam logic [7:0] REG_ARG   = 8'h10;
    localparam logic [7:0] REG_CMD   = 8'h14;
    localparam logic [7:0] REG_DATA  = 8'h1C;

    localparam int FL_CMD_DONE = 0;
    localparam int FL_CMD_RESP = 1;
    localparam int FL_DAT_DONE = 2;
    localparam int FL_DAT_DATA = 3;
    localparam int FL_BLK_DONE = 4;
    localparam int FL_CRC_OK   = 5;

    localparam logic [1:0] RMODE_R1   = 2'd1;
    localparam logic [1:0] DMODE_READ = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CRC     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_ARG,
        S_CMD,
        S_POLL,
        S_RDAT,
        S_OUT,
        S_BACK,
        S_LASTW,
        S_FIN,
        S_ERR
    } state_t;

    function automatic logic [31:0] cmd_word(
        input logic [5:0] idx,
        input logic [6:0] crc,
        input logic       last,
        input logic       commit
    );
        return {10'h0, idx, 1'b0, crc, 2'b00,
                RMODE_R1, DMODE_READ, last, commit};
    endfunction

endpackage

// File: rtl/neosd_wbm_port.sv
// neosd_wbm_port: single-access Wishbone master. req/we/adr/wdat in,
// done (1-cycle, after ack) and rdat out; wbm_* to the neosd slave.
module neosd_wbm_port (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic        busy,
    output logic [31:0] rdat,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    logic stb;

    // A request still held during the done cycle belongs to the
    // access just finished, so it must not start a new one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb       <= 1'b0;
            done      <= 1'b0;
            rdat      <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stb) begin
                if (wbm_ack_i) begin
                    stb  <= 1'b0;
                    done <= 1'b1;
                    rdat <= wbm_dat_i;
                end
            end else if (req && !done) begin
                stb       <= 1'b1;
                wbm_adr_o <= {24'h0, adr};
                wbm_dat_o <= wdat;
                wbm_we_o  <= we;
            end
        end
    end

    assign busy      = stb;
    assign wbm_stb_o = stb;
    assign wbm_cyc_o = stb;
    assign wbm_sel_o = 4'hF;

endmodule

// File: rtl/neosd_blk_seq.sv
// neosd_blk_seq: multi-block read sequencer. start_i/abort_i/cmd_* in;
// busy/done/err status, dout valid/ready stream, Wishbone master out.
module neosd_blk_seq
    import neosd_pkg::*;
#(
    parameter int NBLK_W   = 16,
    parameter int POLL_MAX = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [5:0]        cmd_idx_i,
    input  logic [6:0]        cmd_crc_i,
    input  logic [31:0]       cmd_arg_i,
    input  logic [NBLK_W-1:0] nblk_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [31:0]       dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i
);

    localparam int PCW = (POLL_MAX > 2) ? $clog2(POLL_MAX) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(POLL_MAX - 1);

    state_t            state, state_n;
    logic [NBLK_W-1:0] rem, rem_n;
    logic [PCW-1:0]    pcnt, pcnt_n;
    logic [31:0]       arg, arg_n;
    logic [5:0]        idx, idx_n;
    logic [6:0]        crc, crc_n;
    logic [2:0]        flg, flg_n;
    logic [31:0]       word, word_n;
    err_code_t         code, code_n;
    logic              abort_q, abort_n;

    logic        p_req, p_we, p_done, p_busy;
    logic [7:0]  p_adr;
    logic [31:0] p_wdat, p_rdat;
    logic        active, abort_any;

    neosd_wbm_port u_port (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (p_req),
        .we        (p_we),
        .adr       (p_adr),
        .wdat      (p_wdat),
        .done      (p_done),
        .busy      (p_busy),
        .rdat      (p_rdat),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            rem     <= '0;
            pcnt    <= '0;
            arg     <= '0;
            idx     <= '0;
            crc     <= '0;
            flg     <= '0;
            word    <= '0;
            code    <= ERR_NONE;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            pcnt    <= pcnt_n;
            arg     <= arg_n;
            idx     <= idx_n;
            crc     <= crc_n;
            flg     <= flg_n;
            word    <= word_n;
            code    <= code_n;
            abort_q <= abort_n;
        end
    end

    assign active    = !(state inside {S_IDLE, S_FIN, S_ERR});
    assign abort_any = abort_q | abort_i;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        pcnt_n  = pcnt;
        arg_n   = arg;
        idx_n   = idx;
        crc_n   = crc;
        flg_n   = flg;
        word_n  = word;
        code_n  = code;
        abort_n = active & abort_any;
        p_req   = 1'b0;
        p_we    = 1'b0;
        p_adr   = REG_FLAGS;
        p_wdat  = '0;

        unique case (state)
            S_IDLE: begin
                // abort in the same cycle suppresses the start
                if (start_i && !abort_i) begin
                    state_n = S_CLR;
                    arg_n   = cmd_arg_i;
                    idx_n   = cmd_idx_i;
                    crc_n   = cmd_crc_i;
                    rem_n   = (nblk_i == '0) ? NBLK_W'(1) : nblk_i;
                    pcnt_n  = '0;
                    code_n  = ERR_NONE;
                end
            end
            S_CLR: begin
                p_req = 1'b1;
                p_we  = 1'b1;
                if (p_done) state_n = S_ARG;
            end
            S_ARG: begin
                p_req  = 1'b1;
                p_we   = 1'b1;
                p_adr  = REG_ARG;
                p_wdat = arg;
                if (p_done) state_n = S_CMD;
            end
            S_CMD: begin
                p_req  = 1'b1;
                p_we   = 1'b1;
                p_adr  = REG_CMD;
                p_wdat = cmd_word(idx, crc, rem == NBLK_W'(1), 1'b1);
                if (p_done) state_n = S_POLL;
            end
            S_POLL: begin
                p_req = 1'b1;
                if (p_done) begin
                    flg_n  = {p_rdat[FL_CRC_OK], p_rdat[FL_DAT_DONE],
                              p_rdat[FL_CMD_DONE]};
                    pcnt_n = '0;
                    if (p_rdat[FL_DAT_DATA]) begin
                        state_n = S_RDAT;
                    end else if (p_rdat[FL_BLK_DONE]) begin
                        if (p_rdat[FL_CRC_OK]) begin
                            state_n = S_BACK;
                        end else begin
                            state_n = S_ERR;
                            code_n  = ERR_CRC;
                        end
                    end else if (p_rdat[FL_DAT_DONE] && rem == '0) begin
                        state_n = S_FIN;
                    end else if (pcnt == PC_LAST) begin
                        state_n = S_ERR;
                        code_n  = ERR_TIMEOUT;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end
            end
            S_RDAT: begin
                p_req = 1'b1;
                p_adr = REG_DATA;
                if (p_done) begin
                    word_n  = p_rdat;
                    state_n = S_OUT;
                end
            end
            S_OUT: begin
                if (dout_ready_i) state_n = S_POLL;
            end
            S_BACK: begin
                p_req  = 1'b1;
                p_we   = 1'b1;
                p_wdat = {26'h0, flg[2], 2'b00, flg[1], 1'b0, flg[0]};
                if (p_done) begin
                    rem_n   = (rem == '0) ? rem : rem - 1'b1;
                    state_n = (rem == NBLK_W'(2)) ? S_LASTW : S_POLL;
                end
            end
            S_LASTW: begin
                p_req  = 1'b1;
                p_we   = 1'b1;
                p_adr  = REG_CMD;
                p_wdat = cmd_word(idx, crc, 1'b1, 1'b0);
                if (p_done) state_n = S_POLL;
            end
            S_FIN:   state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Abort only once the bus is quiet; no new access starts meanwhile.
        if (active && abort_any) begin
            p_req = 1'b0;
            if (!p_busy) begin
                state_n = S_ERR;
                code_n  = ERR_ABORT;
                pcnt_n  = '0;
            end
        end
    end

    assign busy_o       = active;
    assign done_o       = (state == S_FIN);
    assign err_o        = (state == S_ERR);
    assign err_code_o   = code;
    assign dout_o       = word;
    assign dout_valid_o = (state == S_OUT);

endmodule
